// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - HI/LO execute unit: single-cycle multiply, iterative restoring divide, mthi/mtlo.
package muldiv_pkg;
    localparam int W_DATA = 32;
    localparam int W_OPER = 3;
    localparam int W_FUNC = 4;
    localparam logic [W_OPER-1:0] OPER_ALUS = 3'd1;
    localparam logic [W_OPER-1:0] OPER_ALUU = 3'd2;
    localparam logic [W_OPER-1:0] OPER_MTHI = 3'd3;
    localparam logic [W_OPER-1:0] OPER_MTLO = 3'd4;
    localparam logic [W_FUNC-1:0] FUNC_MUL  = 4'd1;
    localparam logic [W_FUNC-1:0] FUNC_DIV  = 4'd2;
endpackage

module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic [W_OPER-1:0] oper,
    input  logic [W_FUNC-1:0] func,
    input  logic [W_DATA-1:0] src_a,
    input  logic [W_DATA-1:0] src_b,
    input  logic              flush,
    output logic              stall,
    output logic [W_DATA-1:0] hi,
    output logic [W_DATA-1:0] lo
);
    typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] orig_a_q, orig_a_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        go, is_alu, is_signed;
    logic        mul_dec, div_dec, mthi_dec, mtlo_dec;
    logic        a_neg, b_neg;
    logic [31:0] abs_a, abs_b;
    logic [63:0] ext_a, ext_b, prod;
    logic [64:0] sh;
    logic [32:0] diff;
    logic [31:0] quo, rmd;

    always_comb begin
        go        = valid & ~flush;
        is_signed = (oper == OPER_ALUS);
        is_alu    = is_signed | (oper == OPER_ALUU);
        mul_dec   = go & is_alu & (func == FUNC_MUL);
        div_dec   = go & is_alu & (func == FUNC_DIV);
        mthi_dec  = go & (oper == OPER_MTHI);
        mtlo_dec  = go & (oper == OPER_MTLO);
    end

    assign stall = ~flush & (((state_q == S_IDLE) & div_dec) | (state_q == S_DIV));
    assign hi    = hi_q;
    assign lo    = lo_q;

    // The low 64 bits of a product of 64-bit extended operands are correct for both signednesses.
    always_comb begin
        ext_a = {{32{is_signed & src_a[31]}}, src_a};
        ext_b = {{32{is_signed & src_b[31]}}, src_b};
        prod  = ext_a * ext_b;
        a_neg = is_signed & src_a[31];
        b_neg = is_signed & src_b[31];
        abs_a = a_neg ? -src_a : src_a;
        abs_b = b_neg ? -src_b : src_b;
    end

    // rem_q holds {partial remainder, dividend bits / quotient bits}.
    always_comb begin
        sh   = {rem_q, 1'b0};
        diff = sh[64:32] - {1'b0, dvs_q};
        quo  = rem_q[31:0];
        rmd  = rem_q[63:32];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        orig_a_d  = orig_a_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                if (div_dec) begin
                    rem_d     = {32'h0, abs_a};
                    dvs_d     = abs_b;
                    orig_a_d  = src_a;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dz_d      = (src_b == 32'h0);
                    cnt_d     = 5'd0;
                    state_d   = S_DIV;
                end else if (mul_dec) begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end else if (mthi_dec) begin
                    hi_d = src_a;
                end else if (mtlo_dec) begin
                    lo_d = src_a;
                end
            end
            S_DIV: begin
                if (!diff[32]) begin
                    rem_d = {diff[31:0], sh[31:1], 1'b1};
                end else begin
                    rem_d = sh[63:0];
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (dz_q) begin
                    lo_d = 32'hFFFF_FFFF;
                    hi_d = orig_a_q;
                end else begin
                    lo_d = neg_quo_q ? -quo : quo;
                    hi_d = neg_rem_q ? -rmd : rmd;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            rem_q     <= 64'h0;
            dvs_q     <= 32'h0;
            orig_a_q  <= 32'h0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= 32'h0;
            lo_q      <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            orig_a_q  <= orig_a_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end
endmodule
